// File: rtl/sram_like_slave_pkg.sv
// rtl/sram_like_slave_pkg.sv - shared constants and types for the sram-like responder.
package sram_like_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] WAIT = 1'b1;

   // Response entry: {is_write, read_data}
   localparam int RESP_W = 33;

   function automatic logic size_is_legal(input logic [1:0] size);
      return (size == SIZE_BYTE) || (size == SIZE_HALF) || (size == SIZE_WORD);
   endfunction

endpackage

// File: rtl/sram_like_slave_if.sv
// rtl/sram_like_slave_if.sv - sram-like data bus between the EXE-stage initiator and the responder.
interface sram_like_slave_if;

   logic        data_sram_req;
   logic        data_sram_wr;
   logic [1:0]  data_sram_size;
   logic [31:0] data_sram_addr;
   logic [3:0]  data_sram_wstrb;
   logic [31:0] data_sram_wdata;
   logic        data_sram_addr_ok;
   logic        data_sram_data_ok;
   logic [31:0] data_sram_rdata;

   modport master (
      output data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
             data_sram_wstrb, data_sram_wdata,
      input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
   );

   modport slave (
      input  data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
             data_sram_wstrb, data_sram_wdata,
      output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
   );

endinterface

// File: rtl/sram_like_slave_resp_fifo.sv
// rtl/sram_like_slave_resp_fifo.sv - DEPTH x W in-order response FIFO with occupancy count.
module resp_fifo
   import sram_like_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = RESP_W
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     push,
   input  logic [W-1:0]             push_data,
   input  logic                     pop,
   output logic [W-1:0]             head_data,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          full;
   logic          do_push;
   logic          do_pop;

   assign empty     = (count == '0);
   assign full      = (count == FULL_CNT);
   assign do_pop    = pop && !empty;
   // A push into a full FIFO is only legal when the head leaves in the same cycle.
   assign do_push   = push && (!full || do_pop);
   assign head_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/sram_like_slave.sv
// rtl/sram_like_slave.sv - sram-like responder in front of a 1-cycle-latency synchronous RAM.
// Optional SRAM_LIKE_RAND_DELAY_EN: LFSR-masked response delay instead of a fixed one.
module sram_like_slave
   import sram_like_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DEPTH  = 4,
   parameter int DELAY  = 2
) (
   input  logic                clk,
   input  logic                resetn,
   sram_like_slave_if.slave    bus,
   output logic                ram_en,
   output logic [3:0]          ram_wen,
   output logic [ADDR_W-1:0]   ram_addr,
   output logic [31:0]         ram_wdata,
   input  logic [31:0]         ram_rdata
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] ONE_C   = CW'(1);
   localparam logic [3:0]    DELAY_C = 4'(DELAY);

   logic [CW-1:0]     outstanding;
   logic              addr_ok;
   logic              accept;
   logic              capture_vld;
   logic              capture_wr;
   logic [RESP_W-1:0] push_data;
   logic [RESP_W-1:0] head_data;
   logic              fifo_empty;
   logic [CW-1:0]     fifo_count;
   logic [0:0]        state;
   logic [3:0]        cnt;
   logic [3:0]        delay_val;
   logic              data_ok;

   // Outstanding count is registered, so a slot freed by data_ok reopens next cycle.
   assign addr_ok = resetn && (outstanding < DEPTH_C);
   assign accept  = bus.data_sram_req && addr_ok;

   assign bus.data_sram_addr_ok = addr_ok;

   assign ram_en    = accept;
   assign ram_wen   = (accept && bus.data_sram_wr) ? bus.data_sram_wstrb : 4'd0;
   assign ram_addr  = bus.data_sram_addr[ADDR_W+1:2];
   assign ram_wdata = bus.data_sram_wdata;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         capture_vld <= 1'b0;
         capture_wr  <= 1'b0;
      end else begin
         capture_vld <= accept;
         capture_wr  <= accept && bus.data_sram_wr;
      end
   end

   assign push_data = {capture_wr, capture_wr ? 32'd0 : ram_rdata};

   resp_fifo #(
      .DEPTH (DEPTH),
      .W     (RESP_W)
   ) u_resp_fifo (
      .clk       (clk),
      .resetn    (resetn),
      .push      (capture_vld),
      .push_data (push_data),
      .pop       (data_ok),
      .head_data (head_data),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

`ifdef SRAM_LIKE_RAND_DELAY_EN
   logic [7:0] lfsr;
   logic       unused_lfsr;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lfsr <= 8'h5A;
      end else begin
         lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      end
   end

   assign delay_val   = lfsr[3:0] & DELAY_C;
   assign unused_lfsr = ^lfsr[7:4];
`else
   assign delay_val = DELAY_C;
`endif

   assign data_ok = (state == WAIT) && (cnt == 4'd0) && !fifo_empty;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  cnt   <= delay_val;
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else if (fifo_empty || fifo_count <= ONE_C) begin
                  // A push landing alongside the last pop is picked up from IDLE.
                  state <= IDLE;
               end else begin
                  cnt <= delay_val;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         outstanding <= '0;
      end else begin
         case ({accept, data_ok})
            2'b10:   outstanding <= outstanding + 1'b1;
            2'b01:   outstanding <= outstanding - 1'b1;
            default: outstanding <= outstanding;
         endcase
      end
   end

   assign bus.data_sram_data_ok = data_ok;
   assign bus.data_sram_rdata   = data_ok ? head_data[31:0] : 32'd0;

   // Size and the byte/upper address bits never influence the access; wstrb selects bytes.
   logic unused_req_bits;
   assign unused_req_bits = size_is_legal(bus.data_sram_size) ^ (^bus.data_sram_addr[1:0])
                          ^ (^bus.data_sram_addr[31:ADDR_W+2]) ^ head_data[32];

endmodule

// File: tb/tb_sram_like_slave.sv
// tb/tb_sram_like_slave.sv - self-checking bench for sram_like_slave against a transaction-level model.
module tb_sram_like_slave;

   localparam int ADDR_W = 10;
   localparam int DEPTH  = 4;
`ifdef SRAM_LIKE_RAND_DELAY_EN
   localparam int DELAY  = 15;
`else
   localparam int DELAY  = 2;
`endif

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   sram_like_slave_if bus ();

   logic              ram_en;
   logic [3:0]        ram_wen;
   logic [ADDR_W-1:0] ram_addr;
   logic [31:0]       ram_wdata;
   logic [31:0]       ram_rdata;

   sram_like_slave #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH),
      .DELAY  (DELAY)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .bus       (bus),
      .ram_en    (ram_en),
      .ram_wen   (ram_wen),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata)
   );

   // Physical RAM the DUT drives
   logic [31:0] ram [1<<ADDR_W];
   logic        ram_inited = 1'b0;
   always @(posedge clk) begin
      if (!ram_inited) begin
         foreach (ram[i]) ram[i] <= 32'd0;
         ram_inited <= 1'b1;
      end else if (ram_en) begin
         for (int b = 0; b < 4; b++)
            if (ram_wen[b]) ram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
         ram_rdata <= ram[ram_addr];
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] lfsr_next(input logic [7:0] s);
      return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
   endfunction

   logic [7:0] m_lfsr;
   always @(posedge clk or negedge resetn) begin
      if (!resetn) m_lfsr <= 8'h5A;
      else         m_lfsr <= lfsr_next(m_lfsr);
   end

   typedef struct {
      int          acc;
      logic        wr;
      logic [31:0] data;
   } exp_t;

   exp_t        q[$];
   logic [31:0] mdl [1<<ADDR_W];
   logic [7:0]  lfsr_hist [int];
   int          last_ok = -1000;
   int          tests = 0;
   int          fails = 0;
   logic [31:0] last_rdata;
   logic        last_acc;

   function automatic int delay_for(input logic [7:0] l);
`ifdef SRAM_LIKE_RAND_DELAY_EN
      return int'(l[3:0] & 4'(DELAY));
`else
      return DELAY + 0 * int'(l);
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // One bus cycle: inputs already driven; sample mid-cycle, then advance past the next edge.
   task automatic cycle();
      int          c;
      int          a;
      int          ld;
      int          idx;
      logic        exp_ok;
      logic [31:0] exp_wen;
      @(negedge clk);
      c = cyc;
      lfsr_hist[c] = m_lfsr;
      check("addr_ok", bus.data_sram_addr_ok, resetn && (q.size() < DEPTH));
      last_acc = resetn && bus.data_sram_req && (q.size() < DEPTH);
      exp_wen  = (last_acc && bus.data_sram_wr) ? bus.data_sram_wstrb : 4'd0;
      check("ram_en", ram_en, last_acc);
      check("ram_wen", ram_wen, exp_wen);
      if (last_acc) begin
         check("ram_addr", ram_addr, bus.data_sram_addr[ADDR_W+1:2]);
         check("ram_wdata", ram_wdata, bus.data_sram_wdata);
      end
      exp_ok = 1'b0;
      if (q.size() > 0) begin
         a  = q[0].acc + 2;
         ld = (a <= last_ok) ? last_ok : a;
         if (ld < c && ld + 1 + delay_for(lfsr_hist[ld]) <= c) exp_ok = 1'b1;
      end
      check("data_ok", bus.data_sram_data_ok, exp_ok);
      check("rdata", bus.data_sram_rdata, exp_ok ? q[0].data : 32'd0);
      if (exp_ok) begin
         last_rdata = bus.data_sram_rdata;
         void'(q.pop_front());
         last_ok = c;
      end
      if (last_acc) begin
         idx = int'(bus.data_sram_addr[ADDR_W+1:2]);
         q.push_back('{c, bus.data_sram_wr, bus.data_sram_wr ? 32'd0 : mdl[idx]});
         if (bus.data_sram_wr)
            for (int b = 0; b < 4; b++)
               if (bus.data_sram_wstrb[b]) mdl[idx][8*b +: 8] = bus.data_sram_wdata[8*b +: 8];
      end
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic wr, input logic [31:0] addr, input logic [3:0] strb,
                        input logic [31:0] data);
      bus.data_sram_req   = 1'b1;
      bus.data_sram_wr    = wr;
      bus.data_sram_size  = 2'd2;
      bus.data_sram_addr  = addr;
      bus.data_sram_wstrb = strb;
      bus.data_sram_wdata = data;
      for (int i = 0; i < 100; i++) begin
         cycle();
         if (last_acc) break;
      end
      check("accept_bound", last_acc, 1'b1);
      bus.data_sram_req = 1'b0;
   endtask

   task automatic drain();
      bus.data_sram_req = 1'b0;
      for (int i = 0; i < 2000 && q.size() > 0; i++) cycle();
      check("drain", q.size(), 0);
      repeat (3) cycle();
   endtask

   task automatic do_reset();
      bus.data_sram_req = 1'b0;
      resetn = 1'b0;
      q.delete();
      last_ok = -1000;
   endtask

   initial begin
      foreach (mdl[i]) mdl[i] = 32'd0;
      bus.data_sram_req   = 1'b0;
      bus.data_sram_wr    = 1'b0;
      bus.data_sram_size  = 2'd0;
      bus.data_sram_addr  = 32'd0;
      bus.data_sram_wstrb = 4'd0;
      bus.data_sram_wdata = 32'd0;
      last_rdata = 32'd0;
      last_acc   = 1'b0;

      // Reset: request held high must not be accepted
      bus.data_sram_req = 1'b1;
      repeat (3) cycle();
      bus.data_sram_req = 1'b0;
      resetn = 1'b1;
      repeat (2) cycle();

      // Write then read the same word
      issue(1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
      issue(1'b0, 32'h10, 4'h0, 32'h0);
      drain();
      check("rd_word", last_rdata, 32'hDEADBEEF);

      // Byte write into lane 2
      issue(1'b1, 32'h12, 4'b0100, 32'h00AA0000);
      issue(1'b0, 32'h10, 4'h0, 32'h0);
      drain();
      check("rd_byte", last_rdata, 32'hDEAABEEF);

      // Six reads with req held: fills DEPTH, back-pressure, in-order return
      for (int n = 0; n < 6; n++) issue(1'b0, 32'h10 + 32'(n * 4), 4'h0, 32'h0);
      drain();

      // Random mixed traffic over a small address window for read-after-write hits
      for (int n = 0; n < 120; n++) begin
         bus.data_sram_req   = ($urandom_range(0, 3) != 0);
         bus.data_sram_wr    = $urandom_range(0, 1) == 1;
         bus.data_sram_size  = 2'($urandom_range(0, 2));
         bus.data_sram_addr  = {26'd0, 3'($urandom_range(0, 7)), 2'd0, 1'b0}
                             | 32'($urandom_range(0, 3));
         bus.data_sram_wstrb = 4'($urandom);
         bus.data_sram_wdata = $urandom;
         cycle();
      end
      drain();

      // Reset with three reads in flight
      for (int n = 0; n < 3; n++) issue(1'b0, 32'h10 + 32'(n * 4), 4'h0, 32'h0);
      do_reset();
      bus.data_sram_req = 1'b1;
      repeat (2) cycle();
      bus.data_sram_req = 1'b0;
      resetn = 1'b1;
      repeat (12) cycle();

      // Read stream, spacing driven by the (possibly LFSR-masked) delay
      for (int n = 0; n < 32; n++)
         issue(1'b0, 32'(($urandom_range(0, 7)) * 4), 4'h0, 32'h0);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
